// File: rtl/event_indicator_pkg.sv
// Event indicator shared definitions.
// Board-level defaults for the blink phase length and queue depth.
package event_indicator_pkg;

  localparam int unsigned EVI_N_DEF      = 16;
  localparam int unsigned EVI_PEND_W_DEF = 4;

endpackage

// File: rtl/event_indicator.sv
// Event indicator: stretches 1-cycle event strobes into LED blinks.
// One ON/GAP blink per event; events arriving mid-blink queue up.
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter int unsigned N      = EVI_N_DEF,
  parameter int unsigned PEND_W = EVI_PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_in,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [N-1:0]      T_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] P_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [N-1:0]      timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              led_q, led_d;

  logic term;
  logic gap_term;
  logic pend_nz;
  logic inc;
  logic dec;

  assign term     = (timer_q == '1);
  assign gap_term = (state_q == S_GAP) && term;
  assign pend_nz  = (pend_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (event_in) state_d = S_ON;
      S_ON:   if (term) state_d = S_GAP;
      S_GAP:  if (term) state_d = (pend_nz || event_in) ? S_ON : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;

    if (clear || (state_d != state_q) || (state_q == S_IDLE))
      timer_d = '0;
    else
      timer_d = timer_q + T_ONE;

    // An event landing on an empty GAP end starts the next blink directly.
    inc = event_in && !clear && (state_q != S_IDLE)
       && !(gap_term && !pend_nz);
    dec = gap_term && pend_nz;

    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (inc && !dec) begin
      if (pend_q == '1) ovf_d = 1'b1;
      else pend_d = pend_q + P_ONE;
    end else if (dec && !inc) begin
      pend_d = pend_q - P_ONE;
    end

    led_d = (state_d == S_ON);
  end

  always_comb begin
    led      = led_q;
    busy     = (state_q != S_IDLE);
    pending  = pend_q;
    overflow = ovf_q;
  end

endmodule
